// File: rtl/uart_pkg.sv
// Shared UART definitions: oversampling constants, receiver state encoding
// and the baud-divider helper used by both the RX and TX paths.
package uart_pkg;

  localparam int UART_OS     = 16;
  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } uart_rx_state_e;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int uart_os_div(input int clk_freq, input int baud);
    return (clk_freq + (baud * UART_OS) / 2) / (baud * UART_OS);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic first-word-fallthrough synchronous FIFO. The head entry is visible
// on head_data whenever empty is low; a pop frees a slot in the same cycle.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             full;
  logic             do_pop;
  logic             do_push;

  // Extra pointer MSB separates full from empty when the index bits match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign overflow = push & full & ~do_pop;

  assign head_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/uart_rx_fifo_if.sv
// UART 8N1 receiver: pin synchronizer, 16x oversample deframer and a receive
// FIFO presented on a valid/ready port, with framing and overrun reporting.
module uart_rx_fifo_if
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   uart_rxd,
  output logic [UART_DATA_W-1:0] rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic                   rx_busy,
  output logic                   rx_frame_err,
  output logic                   rx_overrun,
  input  logic                   rx_err_clr
);

  localparam int DIV   = uart_os_div(CLK_FREQ, BAUD);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
  localparam logic [3:0]       MID_TICK  = 4'(UART_OS / 2 - 1);
  localparam logic [3:0]       LAST_TICK = 4'(UART_OS - 1);

  logic                   rxd_meta;
  logic                   rxd_s;
  logic                   rxd_prev;
  logic                   fall;
  logic [CNT_W-1:0]       os_cnt;
  logic                   tick;
  uart_rx_state_e         state;
  logic [3:0]             tick_cnt;
  logic [2:0]             bit_idx;
  logic [UART_DATA_W-1:0] shreg;
  logic                   push;
  logic                   overflow;
  logic                   fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= uart_rxd;
      rxd_s    <= rxd_meta;
      rxd_prev <= rxd_s;
    end
  end

  assign fall = rxd_prev & ~rxd_s;
  assign tick = (os_cnt == DIV_LAST);

  // Realigning on the start edge puts every later sample near bit centre.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        os_cnt <= '0;
    else if ((state == IDLE) && fall)  os_cnt <= '0;
    else if (tick)                     os_cnt <= '0;
    else                               os_cnt <= os_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      tick_cnt     <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (fall) begin
            state    <= START;
            tick_cnt <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (tick_cnt == MID_TICK) begin
              tick_cnt <= '0;
              bit_idx  <= '0;
              state    <= rxd_s ? IDLE : DATA;
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (tick_cnt == LAST_TICK) begin
              tick_cnt <= '0;
              shreg    <= {rxd_s, shreg[UART_DATA_W-1:1]};
              bit_idx  <= bit_idx + 3'd1;
              if (bit_idx == 3'd7) state <= STOP;
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (tick_cnt == LAST_TICK) begin
              tick_cnt <= '0;
              if (rxd_s) begin
                state <= IDLE;
              end else begin
                rx_frame_err <= 1'b1;
                state        <= WAIT_IDLE;
              end
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end
        WAIT_IDLE: begin
          if (rxd_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Push straight from the stop-bit sample so the byte is visible next cycle.
  assign push    = (state == STOP) && tick && (tick_cnt == LAST_TICK) && rxd_s;
  assign rx_busy = (state != IDLE);

  // Handshake: rx_valid means rx_data holds the oldest unread byte; the byte
  // is consumed on any clock edge where rx_valid & rx_ready, otherwise rx_data
  // stays put. rx_ready may be asserted regardless of rx_valid.
  uart_sync_fifo #(
    .WIDTH (UART_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (shreg),
    .pop       (rx_ready),
    .head_data (rx_data),
    .empty     (fifo_empty),
    .overflow  (overflow)
  );

  assign rx_valid = ~fifo_empty;

  // A new drop outranks a clear arriving in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          rx_overrun <= 1'b0;
    else if (overflow)   rx_overrun <= 1'b1;
    else if (rx_err_clr) rx_overrun <= 1'b0;
  end

endmodule

// File: tb/tb_uart_rx_fifo_if.sv
// Directed + randomized bench for uart_rx_fifo_if at 16 clocks per bit with a
// 4-entry FIFO; received bytes are scored against a queue of expected bytes.
module tb_uart_rx_fifo_if;

  localparam int CLK_FREQ   = 1_600_000;
  localparam int BAUD       = 100_000;
  localparam int FIFO_DEPTH = 4;
  localparam int BIT_CLKS   = 16;

  logic       clk;
  logic       rst_n;
  logic       uart_rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_busy;
  logic       rx_frame_err;
  logic       rx_overrun;
  logic       rx_err_clr;

  uart_rx_fifo_if #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .uart_rxd     (uart_rxd),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_busy      (rx_busy),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun),
    .rx_err_clr   (rx_err_clr)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  logic       exp_ovr = 1'b0;
  int n_cmp = 0;
  int n_mis = 0;
  int valid_cycles = 0;
  int fe_cnt = 0;
  int last_rise_cyc = 0;
  int stop_start_cyc = 0;
  bit prev_valid = 1'b0;
  bit rand_rdy_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: samples just after each falling edge, when the inputs for
  // the next rising edge are already settled.
  initial begin
    logic [7:0] exp_b;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        if (rx_valid && !prev_valid) last_rise_cyc = cyc;
        prev_valid = rx_valid;
        if (rx_valid) valid_cycles++;
        if (rx_frame_err) fe_cnt++;
        if (rx_valid && rx_ready) begin
          check("pop_expected", {31'd0, exp_q.size() > 0}, 32'd1);
          if (exp_q.size() > 0) begin
            exp_b = exp_q.pop_front();
            check("pop_data", {24'd0, rx_data}, {24'd0, exp_b});
          end
        end
      end else begin
        prev_valid = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rand_rdy_en) rx_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- driver tasks ----------------
  // Starts and ends on a falling edge; leaves the line at the stop-bit level.
  task automatic drive_frame(input logic [7:0] b, input logic stop_bit, input bit pop_at_push);
    uart_rxd = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    uart_rxd = stop_bit;
    stop_start_cyc = cyc;
    if (pop_at_push) begin
      // Stop sample lands 2 sync + 1 edge + 8 ticks after the stop bit begins.
      repeat (10) @(negedge clk);
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      repeat (BIT_CLKS - 11) @(negedge clk);
    end else begin
      repeat (BIT_CLKS) @(negedge clk);
    end
  endtask

  // Reference model: a good frame enters the FIFO unless it is already full
  // and no byte leaves in that same cycle.
  task automatic send_byte(input logic [7:0] b, input bit pop_at_push);
    if (pop_at_push || exp_q.size() < FIFO_DEPTH) exp_q.push_back(b);
    else exp_ovr = 1'b1;
    drive_frame(b, 1'b1, pop_at_push);
    repeat (4) @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    int waited;
    logic [7:0] rb;

    rst_n      = 1'b0;
    uart_rxd   = 1'b1;
    rx_ready   = 1'b0;
    rx_err_clr = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_data", {24'd0, rx_data}, 32'd0);
    check("rst_busy", {31'd0, rx_busy}, 32'd0);
    check("rst_frame_err", {31'd0, rx_frame_err}, 32'd0);
    check("rst_overrun", {31'd0, rx_overrun}, 32'd0);

    // 1: single byte, consumer always ready
    rx_ready = 1'b1;
    valid_cycles = 0;
    fe_cnt = 0;
    send_byte(8'hA5, 1'b0);
    repeat (4) @(negedge clk);
    lat = last_rise_cyc - stop_start_cyc;
    check("t1_valid_cycles", valid_cycles, 32'd1);
    check("t1_latency_window", {31'd0, (lat >= 9 && lat <= 13)}, 32'd1);
    check("t1_frame_err", fe_cnt, 32'd0);
    check("t1_overrun", {31'd0, rx_overrun}, 32'd0);
    check("t1_queue_empty", exp_q.size(), 32'd0);

    // 2: short low glitch is a false start
    valid_cycles = 0;
    uart_rxd = 1'b0;
    repeat (4) @(negedge clk);
    uart_rxd = 1'b1;
    check("t2_busy_seen", {31'd0, rx_busy}, 32'd1);
    waited = 0;
    while (rx_busy && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("t2_busy_cleared", {31'd0, rx_busy}, 32'd0);
    repeat (20) @(negedge clk);
    check("t2_no_valid", valid_cycles, 32'd0);
    check("t2_no_frame_err", fe_cnt, 32'd0);

    // 3: bad stop bit followed by a held-low line
    drive_frame(8'h3C, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    check("t3_frame_err_pulses", fe_cnt, 32'd1);
    check("t3_busy_while_low", {31'd0, rx_busy}, 32'd1);
    uart_rxd = 1'b1;
    repeat (6) @(negedge clk);
    check("t3_busy_after_high", {31'd0, rx_busy}, 32'd0);
    check("t3_no_valid", valid_cycles, 32'd0);
    fe_cnt = 0;

    // 4: overrun with a stalled consumer, then drain and clear
    rx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b0);
    check("t4_valid", {31'd0, rx_valid}, 32'd1);
    check("t4_head", {24'd0, rx_data}, 32'h01);
    check("t4_overrun", {31'd0, rx_overrun}, {31'd0, exp_ovr});
    rx_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("t4_drained", exp_q.size(), 32'd0);
    check("t4_valid_low", {31'd0, rx_valid}, 32'd0);
    check("t4_overrun_sticky", {31'd0, rx_overrun}, 32'd1);
    rx_err_clr = 1'b1;
    @(negedge clk);
    rx_err_clr = 1'b0;
    @(negedge clk);
    check("t4_overrun_cleared", {31'd0, rx_overrun}, 32'd0);
    exp_ovr = 1'b0;

    // 5: pop coincides with push into a full FIFO, across pointer wrap
    rx_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(0, 255)), 1'b0);
    check("t5_head", {24'd0, rx_data}, {24'd0, exp_q[0]});
    send_byte(8'($urandom_range(0, 255)), 1'b1);
    check("t5_no_overrun", {31'd0, rx_overrun}, 32'd0);
    check("t5_model_count", exp_q.size(), 32'd4);
    check("t5_head_after", {24'd0, rx_data}, {24'd0, exp_q[0]});
    rx_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("t5_drained", exp_q.size(), 32'd0);
    check("t5_valid_low", {31'd0, rx_valid}, 32'd0);

    // 6: reset in the middle of a data byte
    uart_rxd = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    rb = 8'h77;
    for (int i = 0; i < 3; i++) begin
      uart_rxd = rb[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rst_n = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    valid_cycles = 0;
    repeat (20) @(negedge clk);
    check("t6_no_valid", valid_cycles, 32'd0);
    check("t6_busy", {31'd0, rx_busy}, 32'd0);
    check("t6_data", {24'd0, rx_data}, 32'd0);
    send_byte(8'h12, 1'b0);
    repeat (4) @(negedge clk);
    check("t6_next_byte_seen", valid_cycles, 32'd1);
    check("t6_queue_empty", exp_q.size(), 32'd0);

    // Random bytes, gaps and consumer back-pressure
    fe_cnt = 0;
    rand_rdy_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_byte(8'($urandom_range(0, 255)), 1'b0);
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    rand_rdy_en = 1'b0;
    @(negedge clk);
    rx_ready = 1'b1;
    waited = 0;
    while (exp_q.size() > 0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    repeat (2) @(negedge clk);
    check("rnd_drained", exp_q.size(), 32'd0);
    check("rnd_valid_low", {31'd0, rx_valid}, 32'd0);
    check("rnd_no_frame_err", fe_cnt, 32'd0);
    check("rnd_no_overrun", {31'd0, rx_overrun}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
